// File: rtl/edge_to_level_gen_if.sv
// ============================================================================
//  edge_to_level_gen_if
//  Request/level bundle between a strobe source and edge_to_level_gen.
//  Optional statistics signals exist only when EDGE_GEN_STATS_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface edge_to_level_gen_if;
    logic        rise_pulse;
    logic        fall_pulse;
    logic        signal_out;
    logic        busy;
    logic        dropped;
`ifdef EDGE_GEN_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] toggle_count;

    modport master (
        output rise_pulse, fall_pulse,
        input  signal_out, busy, dropped, drop_count, toggle_count
    );
    modport slave (
        input  rise_pulse, fall_pulse,
        output signal_out, busy, dropped, drop_count, toggle_count
    );
`else
    modport master (
        output rise_pulse, fall_pulse,
        input  signal_out, busy, dropped
    );
    modport slave (
        input  rise_pulse, fall_pulse,
        output signal_out, busy, dropped
    );
`endif
endinterface

`default_nettype wire

// File: rtl/edge_to_level_gen.sv
// ============================================================================
//  edge_to_level_gen
//  Rebuilds a minimum-width level from rise/fall strobes with one pending slot.
//  Optional macro EDGE_GEN_STATS_EN adds drop_count / toggle_count outputs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module edge_to_level_gen #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4,
    parameter int CNT_W    = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    edge_to_level_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] c_high_load = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] c_low_load  = CNT_W'(MIN_LOW - 1);

    logic             r_level;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_pend;
    logic             r_busy;
    logic             r_dropped;

    logic             w_conflict;
    logic             w_req_hi;
    logic             w_req_lo;
    logic             w_effective;
    logic             w_same;
    logic             w_cancel;
    logic             w_idle;
    logic             w_toggle;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic             w_pend_nxt;

    assign w_conflict  = bus.rise_pulse & bus.fall_pulse;
    assign w_req_hi    = bus.rise_pulse & ~bus.fall_pulse;
    assign w_req_lo    = bus.fall_pulse & ~bus.rise_pulse;
    assign w_effective = (w_req_hi & ~r_level) | (w_req_lo & r_level);
    assign w_same      = (w_req_hi & r_level) | (w_req_lo & ~r_level);
    assign w_idle      = (r_hcnt == '0);

    // A request for the current level withdraws a pending change, even on the
    // edge where that pending change would otherwise have executed.
    assign w_cancel    = r_pend & w_same;
    assign w_toggle    = w_idle & ~w_cancel & (w_effective | r_pend);

    always_comb begin
        w_hcnt_nxt = r_hcnt;
        w_pend_nxt = r_pend;
        if (w_toggle) begin
            w_hcnt_nxt = r_level ? c_low_load : c_high_load;
            w_pend_nxt = 1'b0;
        end else begin
            if (!w_idle) begin
                w_hcnt_nxt = r_hcnt - 1'b1;
            end
            if (w_cancel) begin
                w_pend_nxt = 1'b0;
            end else if (!w_idle && w_effective) begin
                w_pend_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level   <= 1'b0;
            r_hcnt    <= '0;
            r_pend    <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_level   <= r_level ^ w_toggle;
            r_hcnt    <= w_hcnt_nxt;
            r_pend    <= w_pend_nxt;
            r_busy    <= (w_hcnt_nxt != '0);
            r_dropped <= w_conflict;
        end
    end

    assign bus.signal_out = r_level;
    assign bus.busy       = r_busy;
    assign bus.dropped    = r_dropped;

`ifdef EDGE_GEN_STATS_EN
    logic [15:0] r_drop_count;
    logic [15:0] r_toggle_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count   <= 16'h0000;
            r_toggle_count <= 16'h0000;
        end else begin
            if (w_conflict && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'h0001;
            end
            if (w_toggle) begin
                r_toggle_count <= r_toggle_count + 16'h0001;
            end
        end
    end

    assign bus.drop_count   = r_drop_count;
    assign bus.toggle_count = r_toggle_count;
`endif

endmodule

`default_nettype wire
